// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f sequencing controller: absorb lanes, run rounds, signal completion
module keccak_round_ctrl #(
  parameter int NROUNDS    = 24,
  parameter int RATE_LANES = 17
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       abort_i,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  output logic       lane_we_o,
  output logic [4:0] lane_idx_o,
  output logic       round_en_o,
  output logic [4:0] round_idx_o,
  output logic       state_clr_o,
  output logic       busy_o,
  output logic       done_o,
  input  logic       irq_en_i,
  input  logic       irq_clr_i,
  output logic       irq_o
);

  typedef enum logic [1:0] {IDLE, ABSORB, PERMUTE, DONE} state_e;

  localparam logic [4:0] LAST_LANE  = 5'(RATE_LANES - 1);
  localparam logic [4:0] LAST_ROUND = 5'(NROUNDS - 1);

  state_e     state_q, state_d;
  logic [4:0] lane_q, lane_d;
  logic [4:0] round_q, round_d;
  logic       irq_q, irq_d;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= 5'd0;
      round_q <= 5'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      round_q <= round_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    round_d     = round_q;
    din_ready_o = 1'b0;
    lane_we_o   = 1'b0;
    lane_idx_o  = 5'd0;
    round_en_o  = 1'b0;
    round_idx_o = 5'd0;
    state_clr_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // Clear and start may coincide: the clear lands now, absorb starts next cycle.
        state_clr_o = clear_i;
        if (start_i) begin
          state_d = ABSORB;
          lane_d  = 5'd0;
        end
      end
      ABSORB: begin
        din_ready_o = !abort_i;
        lane_we_o   = din_valid_i && !abort_i;
        lane_idx_o  = lane_q;
        state_clr_o = abort_i;
        if (abort_i) begin
          state_d = IDLE;
        end else if (lane_we_o) begin
          if (lane_q == LAST_LANE) begin
            state_d = PERMUTE;
            round_d = 5'd0;
          end else begin
            lane_d = lane_q + 5'd1;
          end
        end
      end
      PERMUTE: begin
        round_en_o  = !abort_i;
        round_idx_o = round_q;
        state_clr_o = abort_i;
        if (abort_i) begin
          state_d = IDLE;
        end else if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new completion wins over a simultaneous clear.
    irq_d = (done_o && irq_en_i) || (irq_q && !irq_clr_i);
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - randomized self-checking bench for keccak_round_ctrl
module tb_keccak_round_ctrl;
  localparam int NR = 24;
  localparam int RL = 17;

  logic       clk_gen = 1'b0;
  logic       rst_n;
  logic       start_i, clear_i, abort_i, din_valid_i, irq_en_i, irq_clr_i;
  logic       din_ready_o, lane_we_o, round_en_o, state_clr_o, busy_o, done_o, irq_o;
  logic [4:0] lane_idx_o, round_idx_o;

  int   checks = 0;
  int   errors = 0;
  logic exp_irq;

  always #5 clk_gen = ~clk_gen;

  keccak_round_ctrl #(.NROUNDS(NR), .RATE_LANES(RL)) dut (
    .clk_gen(clk_gen), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .abort_i(abort_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .lane_we_o(lane_we_o), .lane_idx_o(lane_idx_o), .round_en_o(round_en_o),
    .round_idx_o(round_idx_o), .state_clr_o(state_clr_o), .busy_o(busy_o),
    .done_o(done_o), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o)
  );

  wire [16:0] obs = {busy_o, done_o, din_ready_o, lane_we_o, lane_idx_o,
                     round_en_o, round_idx_o, state_clr_o, irq_o};

  function automatic logic [16:0] ex(input logic b, input logic d, input logic rd,
                                     input logic we, input logic [4:0] li, input logic re,
                                     input logic [4:0] ri, input logic cl, input logic ir);
    return {b, d, rd, we, li, re, ri, cl, ir};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic drive(input logic s, input logic c, input logic a, input logic v,
                       input logic ie, input logic ic);
    @(posedge clk_gen);
    #1;
    start_i = s; clear_i = c; abort_i = a; din_valid_i = v; irq_en_i = ie; irq_clr_i = ic;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One block: pmode 0 = valid always, 1 = valid 1,0,1,0..., 2 = random valid.
  // abort_lane/abort_round = -1 for none; stop_lane >= 0 returns mid-absorb.
  task automatic do_op(input int pmode, input int abort_lane, input int abort_round,
                       input int stop_lane, input logic ien, input logic iclr, input logic wclr);
    int   acc, idles, t;
    logic v, ab;
    drive(1'b1, wclr, rb(), rb(), ien, 1'b0);
    @(negedge clk_gen);
    chk("idle_start", 0, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, wclr, exp_irq)));
    acc = 0; idles = 0; t = 1;
    while (acc < RL) begin
      if (acc == stop_lane) return;
      if (t > 3000) begin
        checks++; errors++;
        $error("FAIL absorb_timeout cyc=%0d observed=%0d lanes expected=%0d lanes", t, acc, RL);
        return;
      end
      case (pmode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 1);
        default: v = rb();
      endcase
      ab = (acc == abort_lane) && v;
      drive(rb(), rb(), ab, v, ien, 1'b0);
      @(negedge clk_gen);
      chk("absorb", t, 32'(obs), 32'(ex(1, 0, !ab, v && !ab, 5'(acc), 0, 5'd0, ab, exp_irq)));
      if (ab) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, ien, 1'b0);
        @(negedge clk_gen);
        chk("abort_to_idle", t + 1, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, exp_irq)));
        return;
      end
      if (v) acc++; else idles++;
      t++;
    end
    for (int r = 0; r < NR; r++) begin
      ab = (r == abort_round);
      drive(rb(), rb(), ab, rb(), ien, 1'b0);
      @(negedge clk_gen);
      chk("permute", t, 32'(obs), 32'(ex(1, 0, 0, 0, 5'd0, !ab, 5'(r), ab, exp_irq)));
      if (ab) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, ien, 1'b0);
        @(negedge clk_gen);
        chk("abort_to_idle", t + 1, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, exp_irq)));
        drive(1'b0, 1'b0, 1'b0, 1'b0, ien, 1'b0);
        @(negedge clk_gen);
        chk("no_done_after_abort", t + 2, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, exp_irq)));
        return;
      end
      t++;
    end
    drive(rb(), rb(), rb(), rb(), ien, iclr);
    @(negedge clk_gen);
    chk("done", t, 32'(obs), 32'(ex(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, exp_irq)));
    chk("latency", t, 32'(t), 32'(1 + RL + NR + idles));
    exp_irq = ien ? 1'b1 : (iclr ? 1'b0 : exp_irq);
    drive(1'b0, 1'b0, 1'b0, 1'b0, ien, 1'b0);
    @(negedge clk_gen);
    chk("post_done", t + 1, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, exp_irq)));
  endtask

  initial begin
    rst_n = 1'b0; start_i = 0; clear_i = 1'b1; abort_i = 0; din_valid_i = 1;
    irq_en_i = 0; irq_clr_i = 0;
    exp_irq = 1'b0;
    #1;
    chk("reset_clr", 0, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0)));
    clear_i = 1'b0;
    #1;
    chk("reset_state", 0, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0)));
    @(posedge clk_gen);
    @(posedge clk_gen);
    #1 rst_n = 1'b1;

    do_op(0, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    do_op(1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    do_op(0, -1, 10, -1, 1'b1, 1'b0, 1'b0);
    do_op(2, 8, -1, -1, 1'b1, 1'b0, 1'b0);
    do_op(0, -1, -1, -1, 1'b1, 1'b0, 1'b1);
    do_op(2, -1, -1, -1, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk_gen);
    chk("irq_clr_pending", 0, 32'(irq_o), 32'(exp_irq));
    exp_irq = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_gen);
    chk("irq_cleared", 0, 32'(irq_o), 32'(exp_irq));

    do_op(2, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    do_op(0, -1, -1, 5, 1'b0, 1'b0, 1'b0);
    @(posedge clk_gen);
    #1;
    start_i = 0; abort_i = 0; din_valid_i = 1'b1; clear_i = 1'b1; rst_n = 1'b0;
    exp_irq = 1'b0;
    #1;
    chk("midop_reset_clr", 0, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0)));
    clear_i = 1'b0;
    #1;
    chk("midop_reset", 0, 32'(obs), 32'(ex(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0)));
    @(posedge clk_gen);
    #1 rst_n = 1'b1;
    do_op(0, -1, -1, -1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int al, ar;
      al = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RL - 1)) : -1;
      ar = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
      do_op(2, al, ar, -1, rb(), rb(), rb());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
